nand_chain_sequencer: RTL and testbench
=======================================

// Module: nand_chain_sequencer
// PURPOSE
//  Evaluates the cascaded NAND chain y1=~(x0&x1), yk=~(x[k]&y[k-1]) over N inputs.
//  Uses a single shared 2-input NAND unit, one stage per clock.
//  Sits between the lab switch/stimulus logic and the LED/result display.
//  Replaces N-1 parallel gates with one gate, a controller and a start/busy/done handshake.
// PARAMETERS
//  N_INPUTS  4  chain inputs (>=2); N_INPUTS-1 stage results; 4 reproduces e,f,g chain
// PORTS
//  clk        in   1           single system clock, rising edge
//  reset      in   1           asynchronous, active-high; clears all state
//  start      in   1           request evaluation; sampled in IDLE or DONE only
//  in_vec     in   N_INPUTS    chain inputs; bit0=a, bit1=b, bit2=c, bit3=d ...
//  busy       out  1           1 while in RUN
//  done       out  1           1-cycle pulse; stage_out/result valid from this cycle
//  stage_out  out  N_INPUTS-1  bit k-1 = stage k result (N=4: {g,f,e})
//  result     out  1           final stage value (= stage_out[N_INPUTS-2])
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, busy=0, done=0, stage_out=0, result=0, idx=0.
//  - States: IDLE, RUN, DONE.
//  - IDLE: on start=1 at edge T0 -> RUN.
//    Same edge: capture in_vec to cap, acc<=cap-equivalent in_vec[0], idx<=1, clear stage_out.
//  - RUN: each edge computes n = ~(acc & cap[idx]) via the shared NAND unit.
//    stage_out[idx-1]<=n, acc<=n, idx<=idx+1.
//    Edge with idx==N_INPUTS-1 -> DONE; result<=n.
//  - Stage k is registered at edge T0+k.
//    done=1 and busy=0 in the cycle after edge T0+N_INPUTS-1; latency N_INPUTS-1 clocks.
//  - DONE lasts exactly 1 cycle. start=1 there -> RUN (back-to-back, recapture); else -> IDLE.
//  - start during RUN: ignored, not queued. in_vec changes during RUN: no effect (captured).
//  - stage_out/result hold their last value in IDLE until the next accepted start.
//    The accepting edge clears stage_out to 0.
//  - Reset mid-RUN: immediate abort to IDLE. No done pulse. Partial stage_out cleared.
//  - idx width = $clog2(N_INPUTS); never exceeds N_INPUTS-1 (no wrap).
//  - busy and done are never 1 in the same cycle.
// STRUCTURE
//  - Package nand_seq_pkg:
//    - state enum/localparams S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2.
//    - helper function idx_w(N) = $clog2(N).
//  - Sub-module nand2_unit (a,b -> y=~(a&b)), combinational.
//    Instantiated once; the only NAND in the block.
//  - Top: FSM, cap/acc/idx registers, output registers; all outputs registered.
// TESTING
//  1 reset=1 mid-sim -> busy=0, done=0, stage_out=3'b000, result=0 immediately (async, no clk).
//  2 N=4, in_vec=4'b1111, start 1 cycle -> busy 3 cycles, then done=1;
//    stage_out=3'b010, result=0.
//  3 N=4, in_vec=4'b1110 (a=0) -> stage_out=3'b101, result=1.
//    e=1 at T0+1, f=0 at T0+2, g=1 at T0+3.
//  4 in_vec toggled and start re-pulsed during RUN -> result equals captured vector; no second run.
//  5 start held high through DONE with new in_vec=4'b0011 -> immediate second run.
//    busy 1 cycle after done; second stage_out=3'b110.
//  6 reset asserted at T0+2 -> no done pulse; next start runs cleanly from idx=1.
//  Bench: scoreboard = parallel e/f/g gate model compared at each done; exhaustive 16 vectors.

Source files
------------

// File: rtl/nand_seq_pkg.sv
// nand_seq_pkg: shared state encoding and index-width helper for the NAND chain sequencer
package nand_seq_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;
  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/nand2_unit.sv
// nand2_unit: the single shared 2-input NAND gate
module nand2_unit (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = ~(a & b);
endmodule

// File: rtl/nand_chain_sequencer.sv
// nand_chain_sequencer: evaluates a cascaded NAND chain one stage per clock through one shared gate
module nand_chain_sequencer
  import nand_seq_pkg::*;
#(
  parameter int N_INPUTS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [N_INPUTS-1:0] in_vec,
  output logic                busy,
  output logic                done,
  output logic [N_INPUTS-2:0] stage_out,
  output logic                result
);
  localparam int IW = idx_w(N_INPUTS);
  state_t              state, state_nx;
  logic [N_INPUTS-1:0] cap;
  logic                acc;
  logic [IW-1:0]       idx;
  logic                n, last, accept;
  nand2_unit u_nand (.a(acc), .b(cap[idx]), .y(n));
  always_comb begin
    last     = idx == IW'(N_INPUTS - 1);
    accept   = start && state != S_RUN;
    state_nx = accept ? S_RUN :
               state == S_RUN ? (last ? S_DONE : S_RUN) : S_IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      stage_out <= '0;
      result    <= 1'b0;
      cap       <= '0;
      acc       <= 1'b0;
      idx       <= '0;
    end else begin
      state <= state_nx;
      busy  <= state_nx == S_RUN;
      done  <= state_nx == S_DONE;
      if (accept) begin
        cap       <= in_vec;
        acc       <= in_vec[0];
        idx       <= IW'(1);
        stage_out <= '0;
        result    <= 1'b0;
      end else if (state == S_RUN) begin
        stage_out[idx - IW'(1)] <= n;
        acc                     <= n;
        if (last) result <= n;
        else idx <= idx + IW'(1);
      end
    end
  end
endmodule

// File: tb/tb_nand_chain_sequencer.sv
// tb_nand_chain_sequencer: gate-level chain model scoreboard plus directed handshake scenarios
module tb_nand_chain_sequencer;
  localparam int N = 4;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] in_vec = '0;
  logic         busy, done, result;
  logic [N-2:0] stage_out;
  int           checks = 0;
  int           failures = 0;
  nand_chain_sequencer #(.N_INPUTS(N)) dut (
    .clk(clk), .reset(reset), .start(start), .in_vec(in_vec),
    .busy(busy), .done(done), .stage_out(stage_out), .result(result)
  );
  always #5 clk = ~clk;
  function automatic logic [2:0] chain(input logic [3:0] v);
    logic e, f, g;
    e = ~(v[0] & v[1]);
    f = ~(v[2] & e);
    g = ~(v[3] & f);
    return {g, f, e};
  endfunction
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  logic         m_busy, m_done, m_res;
  logic [N-1:0] m_cap;
  logic [N-2:0] m_stage, m_full;
  int           m_k;
  assign m_full = chain(m_cap);
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_stage <= '0; m_res <= 1'b0; m_k <= 0; m_cap <= '0;
    end else if (start && !m_busy) begin
      m_cap <= in_vec; m_k <= 1; m_busy <= 1'b1; m_done <= 1'b0; m_stage <= '0; m_res <= 1'b0;
    end else if (m_busy) begin
      m_stage <= m_full & 3'((1 << m_k) - 1);
      m_k     <= m_k + 1;
      if (m_k == N - 1) begin
        m_busy <= 1'b0; m_done <= 1'b1; m_res <= m_full[N-2];
      end
    end else m_done <= 1'b0;
  end
  always @(negedge clk) begin
    if (!reset) begin
      chk("cyc_busy", 8'(busy), 8'(m_busy));
      chk("cyc_done", 8'(done), 8'(m_done));
      chk("cyc_stage", 8'(stage_out), 8'(m_stage));
      chk("cyc_result", 8'(result), 8'(m_res));
      chk("cyc_excl", 8'(busy & done), 8'd0);
    end
  end
  int nb;
  task automatic pulse(input logic [3:0] v);
    @(negedge clk);
    in_vec = v;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask
  task automatic wait_done();
    nb = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (busy) nb++;
      @(negedge clk);
    end
    chk("done_seen", 8'(done), 8'd1);
  endtask
  initial begin
    #1;
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_stage", 8'(stage_out), 8'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    pulse(4'b1111);
    wait_done();
    chk("t2_busy_cycles", 8'(nb), 8'd3);
    chk("t2_stage", 8'(stage_out), 8'b010);
    chk("t2_result", 8'(result), 8'd0);
    @(negedge clk);
    chk("t2_done_pulse", 8'(done), 8'd0);
    pulse(4'b1110);
    @(negedge clk);
    chk("t3_e", 8'(stage_out), 8'b001);
    @(negedge clk);
    chk("t3_f", 8'(stage_out), 8'b001);
    @(negedge clk);
    chk("t3_g", 8'(stage_out), 8'b101);
    chk("t3_result", 8'(result), 8'd1);
    chk("t3_done", 8'(done), 8'd1);
    repeat (2) @(negedge clk);
    chk("hold_stage", 8'(stage_out), 8'b101);
    pulse(4'b1111);
    in_vec = 4'b0000;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    wait_done();
    chk("t4_stage", 8'(stage_out), 8'b010);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_no_rerun", 8'(busy | done), 8'd0);
    end
    pulse(4'b1111);
    wait_done();
    in_vec = 4'b0011;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    chk("t5_b2b_busy", 8'(busy), 8'd1);
    chk("t5_b2b_cleared", 8'(stage_out), 8'd0);
    wait_done();
    chk("t5_stage", 8'(stage_out), 8'b110);
    pulse(4'b1111);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("t6_async_busy", 8'(busy), 8'd0);
    chk("t6_async_done", 8'(done), 8'd0);
    chk("t6_async_stage", 8'(stage_out), 8'd0);
    chk("t6_async_result", 8'(result), 8'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_no_done", 8'(done), 8'd0);
    end
    reset = 1'b0;
    pulse(4'b1110);
    wait_done();
    chk("t6_clean_stage", 8'(stage_out), 8'b101);
    for (int v = 0; v < 16; v++) begin
      pulse(4'(v));
      wait_done();
      chk("exh_stage", 8'(stage_out), 8'(chain(4'(v))));
      chk("exh_result", 8'(result), 8'(chain(4'(v)) >> 2));
    end
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
